// File: rtl/arduino_bus_responder.sv
// arduino_bus_responder: target side of the byte-serial Arduino memory bus, storing 16-bit words
// and returning read data byte-by-byte with timed ready strobes.
module arduino_bus_responder #(
  parameter int ADDR_WIDTH    = 8,
  parameter int READ_LATENCY  = 2,
  parameter int STROBE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       write_enable,
  input  logic       read_enable,
  input  logic       register_enable,
  input  logic       lower_bit,
  input  logic       upper_bit,
  input  logic [7:0] data_input_pins,
  output logic [7:0] data_output_pins,
  output logic       drive_enable,
  output logic       lower_byte_ready,
  output logic       upper_byte_ready,
  output logic       busy,
  output logic       protocol_error
);
  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] W_ADDR   = 4'd1;
  localparam logic [3:0] R_ADDR   = 4'd2;
  localparam logic [3:0] W_DATA   = 4'd3;
  localparam logic [3:0] W_COMMIT = 4'd4;
  localparam logic [3:0] R_WAIT   = 4'd5;
  localparam logic [3:0] R_LOW    = 4'd6;
  localparam logic [3:0] R_HIGH   = 4'd7;
  localparam logic [3:0] R_HOLD   = 4'd8;
  localparam logic [7:0] W_RL_END = 8'(READ_LATENCY - 1);
  localparam logic [7:0] W_SC_END = 8'(STROBE_CYCLES - 1);

  logic [3:0]  r_state;
  logic        r_lq, r_uq, r_perr;
  logic [3:0]  r_flags;
  logic [15:0] r_addr, r_wdata, r_rdata;
  logic [7:0]  r_cnt;
  logic [15:0] r_mem [2**ADDR_WIDTH];
  logic        w_rise_l, w_rise_u, w_drv;
  logic [15:0] w_raddr;
  logic [ADDR_WIDTH-1:0] w_idx;

  assign w_rise_l = lower_bit & !r_lq;
  assign w_rise_u = upper_bit & !r_uq;
  // A read with no low address byte falls back to low byte 0.
  assign w_raddr  = {r_addr[15:8], r_flags[0] ? r_addr[7:0] : 8'h00};
  assign w_idx    = ADDR_WIDTH'(w_raddr);

  always_ff @(posedge clk) begin
    if (!reset && r_state == W_COMMIT && &r_flags) r_mem[w_idx] <= r_wdata;
    if (r_state == R_WAIT && r_cnt == W_RL_END) r_rdata <= r_mem[w_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_lq    <= 1'b0;
      r_uq    <= 1'b0;
      r_perr  <= 1'b0;
      r_flags <= 4'h0;
      r_cnt   <= 8'h00;
      r_addr  <= 16'h0000;
      r_wdata <= 16'h0000;
    end else begin
      r_lq   <= lower_bit;
      r_uq   <= upper_bit;
      r_perr <= 1'b0;
      case (r_state)
        IDLE: begin
          r_flags <= 4'h0;
          if (write_enable && read_enable) r_perr <= 1'b1;
          else if (write_enable && register_enable) r_state <= W_ADDR;
          else if (read_enable && register_enable) r_state <= R_ADDR;
        end
        W_ADDR:
          if (!write_enable) r_state <= IDLE;
          else if (!register_enable) r_state <= W_DATA;
          else begin
            if (w_rise_l) {r_addr[7:0], r_flags[0]} <= {data_input_pins, 1'b1};
            if (w_rise_u) {r_addr[15:8], r_flags[1]} <= {data_input_pins, 1'b1};
          end
        R_ADDR:
          if (!read_enable) {r_state, r_perr} <= {IDLE, 1'b1};
          else begin
            if (w_rise_l) {r_addr[7:0], r_flags[0]} <= {data_input_pins, 1'b1};
            if (w_rise_u) begin
              {r_addr[15:8], r_flags[1]} <= {data_input_pins, 1'b1};
              r_state <= R_WAIT;
              r_cnt   <= 8'h00;
            end
          end
        W_DATA:
          if (!write_enable) r_state <= W_COMMIT;
          else begin
            if (w_rise_l) {r_wdata[7:0], r_flags[2]} <= {data_input_pins, 1'b1};
            if (w_rise_u) {r_wdata[15:8], r_flags[3]} <= {data_input_pins, 1'b1};
          end
        W_COMMIT: {r_state, r_perr} <= {IDLE, !(&r_flags)};
        R_WAIT:
          if (!read_enable) {r_state, r_perr} <= {IDLE, 1'b1};
          else if (r_cnt == W_RL_END) {r_state, r_cnt, r_perr} <= {R_LOW, 8'h00, !r_flags[0]};
          else r_cnt <= r_cnt + 8'd1;
        R_LOW, R_HIGH:
          if (!read_enable) {r_state, r_perr} <= {IDLE, 1'b1};
          else if (r_cnt == W_SC_END) {r_state, r_cnt} <= {r_state == R_LOW ? R_HIGH : R_HOLD, 8'h00};
          else r_cnt <= r_cnt + 8'd1;
        R_HOLD: if (!read_enable) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_drv            = r_state == R_LOW || r_state == R_HIGH || r_state == R_HOLD;
  assign drive_enable     = w_drv & !write_enable;
  assign lower_byte_ready = r_state == R_LOW;
  assign upper_byte_ready = r_state == R_HIGH;
  assign data_output_pins = r_state == R_LOW ? r_rdata[7:0] : w_drv ? r_rdata[15:8] : 8'h00;
  assign busy             = r_state != IDLE;
  assign protocol_error   = r_perr;
endmodule
